// File: rtl/nco_voice_mixer.sv
// Multi-voice NCO mixer: per-voice phase accumulators time-multiplexed through
// shared sine/square/triangle/sawtooth LUTs with linear interpolation,
// per-waveform arithmetic attenuation, saturating sum and valid/ready output.
module nco_voice_mixer #(
  parameter int NUM_VOICES     = 4,
  parameter int PHASE_WIDTH    = 24,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int INTERP_BITS    = 8,
  parameter int SAMPLE_WIDTH   = 20
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           fcw_wr_en,
  input  logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] fcw_wr_voice,
  input  logic [PHASE_WIDTH-1:0]                         fcw_wr_data,
  input  logic [NUM_VOICES-1:0]                          voice_en,
  input  logic [4:0]                                     sine_shift,
  input  logic [4:0]                                     square_shift,
  input  logic [4:0]                                     triangle_shift,
  input  logic [4:0]                                     sawtooth_shift,
  input  logic                                           sample_req,
  input  logic                                           sample_ready,
  output logic signed [SAMPLE_WIDTH-1:0]                 sample_out,
  output logic                                           sample_valid,
  output logic                                           busy,
  output logic                                           overrun
);

  localparam int VW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W    = SAMPLE_WIDTH + 2 + $clog2(NUM_VOICES);
  localparam int LUT_SIZE = 1 << LUT_ADDR_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (SAMPLE_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t state, state_next;

  // Waveform tables; contents are loaded externally and have no reset value.
  logic signed [SAMPLE_WIDTH-1:0] sine_lut     [LUT_SIZE-1:0];
  logic signed [SAMPLE_WIDTH-1:0] square_lut   [LUT_SIZE-1:0];
  logic signed [SAMPLE_WIDTH-1:0] triangle_lut [LUT_SIZE-1:0];
  logic signed [SAMPLE_WIDTH-1:0] sawtooth_lut [LUT_SIZE-1:0];

  logic [PHASE_WIDTH-1:0]         phase [NUM_VOICES];
  logic [PHASE_WIDTH-1:0]         fcw   [NUM_VOICES];
  logic [VW-1:0]                  voice;
  logic signed [SAMPLE_WIDTH-1:0] a_r [4];
  logic signed [SAMPLE_WIDTH-1:0] b_r [4];
  logic [INTERP_BITS-1:0]         frac_r;
  logic                           en_r;
  logic signed [ACC_W-1:0]        acc;

  logic [LUT_ADDR_WIDTH-1:0]      idx, idx_n;
  logic [4:0]                     shift_vec [4];
  logic signed [SAMPLE_WIDTH-1:0] wave [4];
  logic signed [ACC_W-1:0]        acc_next;
  logic signed [SAMPLE_WIDTH-1:0] sat_val;
  logic                           last_voice;

  // Interpolate between two LUT entries, then attenuate. Shifts of the full
  // sample width or more give 0 rather than the -1 a plain >>> would leave.
  function automatic logic signed [SAMPLE_WIDTH-1:0] mix_wave(
    input logic signed [SAMPLE_WIDTH-1:0] a,
    input logic signed [SAMPLE_WIDTH-1:0] b,
    input logic [INTERP_BITS-1:0]         frac,
    input logic [4:0]                     shift
  );
    logic signed [SAMPLE_WIDTH:0]               diff;
    logic signed [SAMPLE_WIDTH+INTERP_BITS+1:0] prod;
    logic signed [SAMPLE_WIDTH-1:0]             w;
    diff = $signed({b[SAMPLE_WIDTH-1], b}) - $signed({a[SAMPLE_WIDTH-1], a});
    prod = diff * $signed({1'b0, frac});
    prod = (prod >>> INTERP_BITS) + $signed({{(INTERP_BITS + 2){a[SAMPLE_WIDTH-1]}}, a});
    w    = prod[SAMPLE_WIDTH-1:0];
    if (int'(shift) >= SAMPLE_WIDTH) return '0;
    return w >>> shift;
  endfunction

  assign busy = (state != S_IDLE);

  // LUT addressing for the voice currently being looked up.
  always_comb begin
    idx        = phase[voice][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
    idx_n      = idx + LUT_ADDR_WIDTH'(1);
    last_voice = (int'(voice) == NUM_VOICES - 1);
  end

  // Per-waveform contributions, running sum and output saturation.
  always_comb begin
    shift_vec[0] = sine_shift;
    shift_vec[1] = square_shift;
    shift_vec[2] = triangle_shift;
    shift_vec[3] = sawtooth_shift;
    acc_next     = acc;
    for (int unsigned k = 0; k < 4; k++) begin
      wave[k] = mix_wave(a_r[k], b_r[k], frac_r, shift_vec[k]);
    end
    if (en_r) begin
      for (int unsigned k = 0; k < 4; k++) begin
        acc_next = acc_next +
                   $signed({{(ACC_W - SAMPLE_WIDTH){wave[k][SAMPLE_WIDTH-1]}}, wave[k]});
      end
    end
    if (acc_next > SAT_HI)      sat_val = {1'b0, {(SAMPLE_WIDTH - 1){1'b1}}};
    else if (acc_next < SAT_LO) sat_val = {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};
    else                        sat_val = acc_next[SAMPLE_WIDTH-1:0];
  end

  // Sequencer next-state: one LOOKUP/ACCUM pair per voice, then hold OUTPUT.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (sample_req) state_next = S_LOOKUP;
      S_LOOKUP: state_next = S_ACCUM;
      S_ACCUM:  state_next = last_voice ? S_OUTPUT : S_LOOKUP;
      S_OUTPUT: if (sample_valid && sample_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Datapath: FCW file, phase accumulators, LUT pipeline and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        fcw[v]   <= '0;
      end
      for (int unsigned k = 0; k < 4; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
      voice        <= '0;
      frac_r       <= '0;
      en_r         <= 1'b0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (fcw_wr_en && (int'(fcw_wr_voice) < NUM_VOICES)) fcw[fcw_wr_voice] <= fcw_wr_data;
      if (sample_req && (state != S_IDLE)) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (sample_req) begin
            acc   <= '0;
            voice <= '0;
          end
        end
        S_LOOKUP: begin
          a_r[0] <= sine_lut[idx];      b_r[0] <= sine_lut[idx_n];
          a_r[1] <= square_lut[idx];    b_r[1] <= square_lut[idx_n];
          a_r[2] <= triangle_lut[idx];  b_r[2] <= triangle_lut[idx_n];
          a_r[3] <= sawtooth_lut[idx];  b_r[3] <= sawtooth_lut[idx_n];
          frac_r <= phase[voice][PHASE_WIDTH-LUT_ADDR_WIDTH-1 -: INTERP_BITS];
          en_r   <= voice_en[voice];
        end
        S_ACCUM: begin
          acc          <= acc_next;
          // Reads the pre-write FCW, so a same-cycle write lands next sample.
          phase[voice] <= en_r ? (phase[voice] + fcw[voice]) : '0;
          if (last_voice) begin
            sample_out   <= sat_val;
            sample_valid <= 1'b1;
          end else begin
            voice <= voice + VW'(1);
          end
        end
        S_OUTPUT: begin
          if (sample_valid && sample_ready) sample_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
